key_slot_sequencer: RTL and testbench

//  Parametrised successor to the 2-bit key-select counter in the compression/encryption top level.
//  - Steps through NUM_KEYS key slots while keys are configured, and drives one-hot write enables

---
 rtl/key_seq_pkg.sv | 22 ++
 rtl/key_slot_sequencer_mod_counter.sv | 41 ++++
 rtl/key_slot_sequencer.sv | 151 +++++++++++++++
 tb/tb_key_slot_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/key_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module     : key_seq_pkg
// Description: Shared types and constants for the key slot sequencer.
//              state_t      - sequencer phase (IDLE / LOAD / RUN)
//              MODE_SAT     - refuse key words once every slot is loaded
//              MODE_WRAP    - keep accepting, overwriting from slot 0
// Revision   : 1.0 - initial release
// ============================================================================
package key_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int MODE_SAT  = 0;
  localparam int MODE_WRAP = 1;

endpackage
`default_nettype wire

// File: rtl/key_slot_sequencer_mod_counter.sv
`default_nettype none
// ============================================================================
// Module     : mod_counter
// Description: Modulo-MOD up counter with explicit wrap at MOD-1 (no reliance
//              on a power-of-two rollover).
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   en     in   advance the count
//   clr    in   synchronous clear, takes priority over en
//   count  out  current count, W bits
//   tc     out  count is at its terminal value MOD-1
// Revision   : 1.0 - initial release
// ============================================================================
module mod_counter #(
  parameter int MOD = 4,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign tc = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/key_slot_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : key_slot_sequencer
// Description: Loads NUM_KEYS key slots during configuration with one-hot
//              write enables, then rotates the active key index on data-block
//              boundaries during the run phase.
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   key_config  in   1 = configuration phase, 0 = run phase
//   in_valid    in   key word present
//   in_ready    out  slot available (accept = in_valid & in_ready)
//   key_we      out  one-hot slot write enable, same cycle as accept
//   wr_idx      out  next slot to be written
//   keys_loaded out  every slot written since the last LOAD entry
//   blk_done    in   end-of-data-block pulse
//   rd_idx      out  active key slot for the datapath
//   cfg_err     out  sticky: word offered while refused during LOAD
// Revision   : 1.0 - initial release
// ============================================================================
module key_slot_sequencer
  import key_seq_pkg::*;
#(
  parameter  int NUM_KEYS   = 4,
  parameter  int WRAP_MODE  = MODE_SAT,
  parameter  int ROT_PERIOD = 0,
  parameter  int ROT_W      = 8,
  localparam int IDX_W      = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_config,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NUM_KEYS-1:0] key_we,
  output logic [IDX_W-1:0]    wr_idx,
  output logic                keys_loaded,
  input  logic                blk_done,
  output logic [IDX_W-1:0]    rd_idx,
  output logic                cfg_err
);

  localparam logic WRAP_EN = (WRAP_MODE == MODE_WRAP);

  state_t state;
  state_t state_next;

  logic accept;
  logic load_entry;
  logic partial_abort;
  logic wr_last;
  logic blk_evt;
  logic rot_hit;
  logic rot_step;
  logic rd_wrap_unused;  // rd_idx wrap indication is not needed here

  // Any entry into LOAD restarts the whole key set; in_ready is derived from
  // the registered state, so no word can be accepted on the entry cycle.
  assign load_entry    = (state != LOAD) && key_config;
  assign partial_abort = (state == LOAD) && !key_config && !keys_loaded;
  assign accept        = in_valid && in_ready;
  assign blk_evt       = (state == RUN) && blk_done;
  assign rot_step      = blk_evt && rot_hit;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (key_config) state_next = LOAD;
      LOAD:    if (!key_config) state_next = keys_loaded ? RUN : IDLE;
      RUN:     if (key_config) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready = 1'b0;
    key_we   = '0;
    if (state == LOAD) begin
      // Gating by key_config means a falling key_config never accepts a word.
      in_ready = key_config && (!keys_loaded || WRAP_EN);
      if (in_valid && in_ready) key_we = NUM_KEYS'(1) << wr_idx;
    end
  end

  // ---------------- slot indices ----------------
  mod_counter #(.MOD(NUM_KEYS), .W(IDX_W)) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .clr   (load_entry || partial_abort),
    .count (wr_idx),
    .tc    (wr_last)
  );

  // Clear has priority over enable, so a LOAD entry coinciding with a
  // rotating blk_done leaves rd_idx at 0.
  mod_counter #(.MOD(NUM_KEYS), .W(IDX_W)) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rot_step),
    .clr   (load_entry),
    .count (rd_idx),
    .tc    (rd_wrap_unused)
  );

  // ---------------- status flags ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_loaded <= 1'b0;
      cfg_err     <= 1'b0;
    end else if (load_entry) begin
      keys_loaded <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      if (accept && wr_last) keys_loaded <= 1'b1;
      if ((state == LOAD) && in_valid && key_config && !in_ready) cfg_err <= 1'b1;
    end
  end

  // ---------------- block counter ----------------
  generate
    if (ROT_PERIOD > 0) begin : g_rot
      localparam logic [ROT_W-1:0] BLK_LAST = ROT_W'(ROT_PERIOD - 1);
      logic [ROT_W-1:0] blk_cnt;

      assign rot_hit = (blk_cnt == BLK_LAST);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          blk_cnt <= '0;
        end else if (load_entry) begin
          blk_cnt <= '0;
        end else if (blk_evt) begin
          blk_cnt <= rot_hit ? '0 : blk_cnt + 1'b1;
        end
      end
    end else begin : g_no_rot
      // No rotation: rd_idx stays on slot 0 for the whole run phase.
      assign rot_hit = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_slot_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : tb_key_slot_sequencer
// Description: Randomized self-checking bench. Three sequencer instances with
//              different slot counts, wrap modes and rotation periods share
//              one random stimulus stream; each is compared every cycle with
//              a count-based reference model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_key_slot_sequencer;

  localparam int NI = 3;
  localparam int NKA [NI] = '{4, 3, 5};
  localparam int WMA [NI] = '{0, 1, 0};
  localparam int RPA [NI] = '{2, 3, 0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_config = 1'b0;
  logic in_valid = 1'b0;
  logic blk_done = 1'b0;

  always #5 clk = ~clk;

  logic       rdy_a, kl_a, ce_a;
  logic [3:0] we_a;
  logic [1:0] wi_a, ri_a;
  logic       rdy_b, kl_b, ce_b;
  logic [2:0] we_b;
  logic [1:0] wi_b, ri_b;
  logic       rdy_c, kl_c, ce_c;
  logic [4:0] we_c;
  logic [2:0] wi_c, ri_c;

  key_slot_sequencer #(.NUM_KEYS(4), .WRAP_MODE(0), .ROT_PERIOD(2), .ROT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .key_config(key_config), .in_valid(in_valid),
    .in_ready(rdy_a), .key_we(we_a), .wr_idx(wi_a), .keys_loaded(kl_a),
    .blk_done(blk_done), .rd_idx(ri_a), .cfg_err(ce_a));

  key_slot_sequencer #(.NUM_KEYS(3), .WRAP_MODE(1), .ROT_PERIOD(3), .ROT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .key_config(key_config), .in_valid(in_valid),
    .in_ready(rdy_b), .key_we(we_b), .wr_idx(wi_b), .keys_loaded(kl_b),
    .blk_done(blk_done), .rd_idx(ri_b), .cfg_err(ce_b));

  key_slot_sequencer #(.NUM_KEYS(5), .WRAP_MODE(0), .ROT_PERIOD(0), .ROT_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .key_config(key_config), .in_valid(in_valid),
    .in_ready(rdy_c), .key_we(we_c), .wr_idx(wi_c), .keys_loaded(kl_c),
    .blk_done(blk_done), .rd_idx(ri_c), .cfg_err(ce_c));

  logic [31:0] o_rdy [NI];
  logic [31:0] o_we  [NI];
  logic [31:0] o_wi  [NI];
  logic [31:0] o_kl  [NI];
  logic [31:0] o_ri  [NI];
  logic [31:0] o_ce  [NI];

  assign o_rdy[0] = 32'(rdy_a); assign o_we[0] = 32'(we_a); assign o_wi[0] = 32'(wi_a);
  assign o_kl[0]  = 32'(kl_a);  assign o_ri[0] = 32'(ri_a); assign o_ce[0] = 32'(ce_a);
  assign o_rdy[1] = 32'(rdy_b); assign o_we[1] = 32'(we_b); assign o_wi[1] = 32'(wi_b);
  assign o_kl[1]  = 32'(kl_b);  assign o_ri[1] = 32'(ri_b); assign o_ce[1] = 32'(ce_b);
  assign o_rdy[2] = 32'(rdy_c); assign o_we[2] = 32'(we_c); assign o_wi[2] = 32'(wi_c);
  assign o_kl[2]  = 32'(kl_c);  assign o_ri[2] = 32'(ri_c); assign o_ce[2] = 32'(ce_c);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0=idle 1=configuring 2=running; words = words
  // accepted since configuration started; blocks = blocks seen while running.
  int phase  [NI];
  int words  [NI];
  int blocks [NI];
  bit err    [NI];

  function automatic void model_reset();
    for (int i = 0; i < NI; i++) begin
      phase[i] = 0; words[i] = 0; blocks[i] = 0; err[i] = 1'b0;
    end
  endfunction

  function automatic bit exp_ready(int i);
    return (phase[i] == 1) && key_config && ((words[i] < NKA[i]) || (WMA[i] == 1));
  endfunction

  function automatic void model_step();
    for (int i = 0; i < NI; i++) begin
      bit rdy = exp_ready(i);
      if (phase[i] != 1 && key_config) begin
        phase[i] = 1; words[i] = 0; blocks[i] = 0; err[i] = 1'b0;
      end else if (phase[i] == 1) begin
        if (in_valid && rdy) words[i]++;
        if (in_valid && key_config && !rdy) err[i] = 1'b1;
        if (!key_config) begin
          if (words[i] >= NKA[i]) phase[i] = 2;
          else begin phase[i] = 0; words[i] = 0; end
        end
      end else if (phase[i] == 2 && blk_done) begin
        blocks[i]++;
      end
    end
  endfunction

  task automatic check_all(input string sfx);
    for (int i = 0; i < NI; i++) begin
      bit          rdy = exp_ready(i);
      logic [31:0] we  = (rdy && in_valid) ? (32'd1 << (words[i] % NKA[i])) : 32'd0;
      logic [31:0] ri  = (RPA[i] == 0) ? 32'd0 : 32'((blocks[i] / RPA[i]) % NKA[i]);
      check($sformatf("in_ready%0d%s", i, sfx), o_rdy[i], 32'(rdy));
      check($sformatf("key_we%0d%s", i, sfx), o_we[i], we);
      check($sformatf("wr_idx%0d%s", i, sfx), o_wi[i], 32'(words[i] % NKA[i]));
      check($sformatf("keys_loaded%0d%s", i, sfx), o_kl[i], 32'(words[i] >= NKA[i]));
      check($sformatf("rd_idx%0d%s", i, sfx), o_ri[i], ri);
      check($sformatf("cfg_err%0d%s", i, sfx), o_ce[i], 32'(err[i]));
    end
  endtask

  initial begin
    int  hold = 6;
    bit  forced = 1'b0;
    bit  do_rst;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("_rst");
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      if (hold == 0) begin
        key_config = ~key_config;
        hold = key_config ? $urandom_range(2, 16) : $urandom_range(5, 40);
      end else begin
        hold--;
      end
      in_valid = ($urandom_range(0, 1) == 1);
      blk_done = ($urandom_range(0, 9) < 4);
      do_rst = ($urandom_range(0, 399) == 0);
      // One reset deliberately landed mid-configuration with two slots written.
      if (!forced && phase[0] == 1 && words[0] == 2) begin
        do_rst = 1'b1;
        forced = 1'b1;
      end
      rst_n = !do_rst;
      #1;
      if (do_rst) begin
        model_reset();
        check_all("_async_rst");
      end else begin
        check_all("");
      end
      @(posedge clk);
      if (rst_n) model_step();
    end
    check("forced_mid_load_reset_seen", 32'(forced), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
